// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller, EX/MEM consumer driving a req/ack data memory.
// Optional macro MEM_TIMEOUT_EN: abort accesses left unacked for TIMEOUT_CYCLES.
module mem_stage_ctrl #(
   parameter int DATA_W         = 16,
   parameter int REG_W          = 3,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              BranchIn,
   input  logic              MemReadIn,
   input  logic              MemWriteIn,
   input  logic              MemtoRegIn,
   input  logic              ZeroIn,
   input  logic              RegWriteIn,
   input  logic [DATA_W-1:0] aluResultIn,
   input  logic [DATA_W-1:0] storeDataIn,
   input  logic [DATA_W-1:0] branchTargetIn,
   input  logic [REG_W-1:0]  regDstIn,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              PCSrc,
   output logic [DATA_W-1:0] branchTarget,
   output logic [DATA_W-1:0] readDataOut,
   output logic [DATA_W-1:0] aluResultOut,
   output logic [REG_W-1:0]  regDstOut,
   output logic              MemtoRegOut,
   output logic              RegWriteOut,
   output logic              memFault
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state;
   state_t            state_nx;
   logic              access_req;
   logic              abort;
   logic [REG_W-1:0]  lat_rd;
   logic              lat_rw;
   logic              lat_m2r;

   assign access_req = MemReadIn | MemWriteIn;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign abort = (state == ACCESS) & ~mem_ack & (cnt == CNT_LAST);

   // count unacked ACCESS cycles; emit a one-cycle fault on abort
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         memFault <= 1'b0;
      end else begin
         memFault <= abort;
         if (state == IDLE)
            cnt <= '0;
         else if (!mem_ack)
            cnt <= cnt + 1'b1;
      end
   end
`else
   assign abort    = 1'b0;
   assign memFault = 1'b0;
`endif

   // branch resolution is purely combinational
   assign branchTarget = branchTargetIn;
   assign PCSrc        = BranchIn & ZeroIn & ~stall;

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next state and stall
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      unique case (state)
         IDLE: begin
            stall = access_req;
            if (access_req)
               state_nx = ACCESS;
         end
         ACCESS: begin
            stall = ~mem_ack & ~abort;
            if (mem_ack | abort)
               state_nx = IDLE;
         end
      endcase
   end

   // memory request, latched op fields and MEM/WB register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         lat_rd       <= '0;
         lat_rw       <= 1'b0;
         lat_m2r      <= 1'b0;
         readDataOut  <= '0;
         aluResultOut <= '0;
         regDstOut    <= '0;
         MemtoRegOut  <= 1'b0;
         RegWriteOut  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               readDataOut <= '0;
               if (access_req) begin
                  mem_req     <= 1'b1;
                  mem_we      <= MemWriteIn;
                  mem_addr    <= aluResultIn;
                  mem_wdata   <= storeDataIn;
                  lat_rd      <= regDstIn;
                  lat_rw      <= RegWriteIn;
                  lat_m2r     <= MemtoRegIn & ~MemWriteIn;
                  RegWriteOut <= 1'b0;
                  MemtoRegOut <= 1'b0;
               end else begin
                  aluResultOut <= aluResultIn;
                  regDstOut    <= regDstIn;
                  RegWriteOut  <= RegWriteIn;
                  MemtoRegOut  <= MemtoRegIn;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  mem_req      <= 1'b0;
                  aluResultOut <= mem_addr;
                  regDstOut    <= lat_rd;
                  RegWriteOut  <= lat_rw;
                  MemtoRegOut  <= lat_m2r;
                  readDataOut  <= mem_we ? '0 : mem_rdata;
               end else if (abort) begin
                  mem_req     <= 1'b0;
                  RegWriteOut <= 1'b0;
                  MemtoRegOut <= 1'b0;
                  readDataOut <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: random ops against a memory responder and a writeback scoreboard.
// Timeout checks are built only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        BranchIn, MemReadIn, MemWriteIn, MemtoRegIn, ZeroIn, RegWriteIn;
   logic [15:0] aluResultIn, storeDataIn, branchTargetIn;
   logic [2:0]  regDstIn;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall, PCSrc, MemtoRegOut, RegWriteOut, memFault;
   logic [15:0] branchTarget, readDataOut, aluResultOut;
   logic [2:0]  regDstOut;

   always #5 clock = ~clock;

   mem_stage_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .BranchIn(BranchIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
      .MemtoRegIn(MemtoRegIn), .ZeroIn(ZeroIn), .RegWriteIn(RegWriteIn),
      .aluResultIn(aluResultIn), .storeDataIn(storeDataIn),
      .branchTargetIn(branchTargetIn), .regDstIn(regDstIn),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .PCSrc(PCSrc), .branchTarget(branchTarget),
      .readDataOut(readDataOut), .aluResultOut(aluResultOut),
      .regDstOut(regDstOut), .MemtoRegOut(MemtoRegOut),
      .RegWriteOut(RegWriteOut), .memFault(memFault)
   );

   typedef struct packed {
      logic [15:0] alu;
      logic [15:0] rdata;
      logic [2:0]  rd;
      logic        rw;
      logic        m2r;
   } wb_t;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } tx_t;

   wb_t         wb_q[$];
   tx_t         tx_q[$];
   int          lat_q[$];
   logic [15:0] ram[256];
   logic [15:0] ref_mem[256];
   int          total = 0;
   int          bad = 0;
   bit          resp_en = 0;
   bit          mon_en = 0;
   int          force_k = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired", nm);
   endtask

   task automatic drive_idle();
      {BranchIn, MemReadIn, MemWriteIn, MemtoRegIn, ZeroIn, RegWriteIn} = '0;
      aluResultIn = '0;
      storeDataIn = '0;
      branchTargetIn = '0;
      regDstIn = '0;
   endtask

   // issue one EX/MEM op, hold it while stalled, check branch and stall length
   task automatic run_op(input bit br, input bit z, input bit rd_, input bit wr_,
                         input bit m2r, input bit rw, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [15:0] bt,
                         input logic [2:0] rd);
      wb_t e;
      tx_t t;
      bit  mem;
      int  n;
      int  k;
      BranchIn = br; ZeroIn = z; MemReadIn = rd_; MemWriteIn = wr_;
      MemtoRegIn = m2r; RegWriteIn = rw; aluResultIn = alu;
      storeDataIn = sd; branchTargetIn = bt; regDstIn = rd;
      mem = rd_ | wr_;
      e.alu = alu; e.rd = rd; e.rw = rw; e.m2r = m2r; e.rdata = '0;
      if (mem) begin
         t.we = wr_; t.addr = alu; t.wdata = sd;
         tx_q.push_back(t);
         if (wr_) begin
            e.m2r = 1'b0;
            ref_mem[alu[7:0]] = sd;
         end else begin
            e.rdata = ref_mem[alu[7:0]];
         end
      end
      wb_q.push_back(e);
      mon_en = 1;
      n = 0;
      @(negedge clock); #1;
      if (mem) check("pcsrc_while_stalled", PCSrc, 0);
      while (stall && n < 40) begin
         n++;
         @(negedge clock); #1;
      end
      if (stall) flag("stall_release");
      check("pcsrc", PCSrc, br & z);
      check("branch_target", branchTarget, bt);
      if (mem) begin
         k = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
         check("stall_cycles_mem", n, k);
      end else begin
         check("stall_cycles_alu", n, 0);
      end
      @(posedge clock); #1;
   endtask

   // writeback monitor: every unstalled cycle retires one op into MEM/WB
   initial begin : monitor
      wb_t e;
      forever begin
         @(negedge clock); #1;
         if (mon_en && reset_n && !stall) begin
            @(posedge clock); #1;
            if (wb_q.size() == 0) begin
               flag("wb_unexpected");
            end else begin
               e = wb_q.pop_front();
               check("wb_alu", aluResultOut, e.alu);
               check("wb_rdata", readDataOut, e.rdata);
               check("wb_rd", regDstOut, e.rd);
               check("wb_regwrite", RegWriteOut, e.rw);
               check("wb_memtoreg", MemtoRegOut, e.m2r);
            end
         end
      end
   end

   // memory responder: checks each request, acks after k ACCESS cycles
   initial begin : responder
      tx_t t;
      int  k;
      forever begin
         @(negedge clock);
         if (resp_en && mem_req) begin
            if (tx_q.size() == 0) begin
               flag("extra_request");
               t = '0;
            end else begin
               t = tx_q.pop_front();
               check("req_we", mem_we, t.we);
               check("req_addr", mem_addr, t.addr);
               check("req_wdata", mem_wdata, t.wdata);
            end
            k = (force_k != 0) ? force_k : $urandom_range(1, 5);
            lat_q.push_back(k);
            for (int i = 1; i < k; i++) begin
               @(negedge clock);
               check("req_held", mem_req, 1);
               check("addr_held", mem_addr, t.addr);
               check("wdata_held", {mem_we, mem_wdata}, {t.we, t.wdata});
            end
            mem_ack = 1'b1;
            if (mem_we) ram[mem_addr[7:0]] = mem_wdata;
            else mem_rdata = ram[mem_addr[7:0]];
            @(negedge clock);
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            check("req_drop", mem_req, 0);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin : main
      logic [15:0] v;
      int          kind;
      int          n;
      drive_idle();
      mem_ack = 1'b0;
      mem_rdata = 16'h5a5a;
      for (int i = 0; i < 256; i++) begin
         v = 16'($urandom);
         ram[i] = v;
         ref_mem[i] = v;
      end
      ram[8'h40] = 16'hBEEF;
      ref_mem[8'h40] = 16'hBEEF;

      repeat (3) @(posedge clock);
      #1;
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_stall", stall, 0);
      check("rst_regwrite", RegWriteOut, 0);
      check("rst_alu", aluResultOut, 0);
      check("rst_fault", memFault, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      resp_en = 1;

      run_op(0, 0, 0, 0, 0, 1, 16'h1234, 16'h0, 16'h0, 3'd3);
      force_k = 1;
      run_op(0, 0, 1, 0, 1, 1, 16'h0040, 16'h0, 16'h0, 3'd5);
      force_k = 4;
      run_op(0, 0, 0, 1, 0, 0, 16'h0010, 16'hA5A5, 16'h0, 3'd2);
      force_k = 0;
      run_op(1, 1, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0100, 3'd0);
      run_op(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0100, 3'd0);

      for (int j = 0; j < 200; j++) begin
         kind = $urandom_range(0, 3);
         v = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
         run_op(1'($urandom), 1'($urandom), kind[0], kind[1],
                1'($urandom), 1'($urandom), v, 16'($urandom),
                16'($urandom), 3'($urandom));
      end
      mon_en = 0;
      drive_idle();
      check("wb_q_drained", wb_q.size(), 0);
      check("tx_q_drained", tx_q.size(), 0);

      // reset during the second ACCESS cycle of a load
      resp_en = 0;
      MemReadIn = 1; MemtoRegIn = 1; RegWriteIn = 1;
      aluResultIn = 16'h0123; regDstIn = 3'd6;
      @(posedge clock); #1;
      check("rst_mid_req_up", mem_req, 1);
      @(posedge clock); #3;
      reset_n = 1'b0;
      drive_idle();
      #1;
      check("rst_mid_req", mem_req, 0);
      check("rst_mid_stall", stall, 0);
      check("rst_mid_addr", mem_addr, 0);
      check("rst_mid_regwrite", RegWriteOut, 0);
      check("rst_mid_rdata", readDataOut, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(negedge clock);
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
      @(posedge clock); #1;
      mem_ack = 1'b0;
      check("late_ack_regwrite", RegWriteOut, 0);
      check("late_ack_rdata", readDataOut, 0);
      check("late_ack_req", mem_req, 0);
      check("late_ack_stall", stall, 0);

`ifdef MEM_TIMEOUT_EN
      // unacked load must abort after 15 ACCESS cycles
      MemReadIn = 1; MemtoRegIn = 1; RegWriteIn = 1;
      aluResultIn = 16'h0200; regDstIn = 3'd4;
      n = 0;
      @(negedge clock); #1;
      while (stall && n < 40) begin
         n++;
         @(negedge clock); #1;
      end
      check("timeout_stall_cycles", n, 15);
      check("timeout_no_fault_yet", memFault, 0);
      @(posedge clock); #1;
      drive_idle();
      check("timeout_fault", memFault, 1);
      check("timeout_regwrite", RegWriteOut, 0);
      check("timeout_rdata", readDataOut, 0);
      check("timeout_req", mem_req, 0);
      @(posedge clock); #1;
      check("timeout_fault_pulse", memFault, 0);
      resp_en = 1;
      run_op(0, 0, 0, 0, 0, 1, 16'h4321, 16'h0, 16'h0, 3'd1);
      mon_en = 0;
      drive_idle();
      check("timeout_after_drained", wb_q.size(), 0);
`else
      n = 0;
`endif

      repeat (2) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
